// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the LC-3 MAR/MDR memory access sequencer.
package mem_ctrl_pkg;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_MAX_DATA_RUN   = 4;
    localparam int unsigned WAIT_W             = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAR  = 3'd1,
        ST_MDRW = 3'd2,
        ST_ACC  = 3'd3,
        ST_MDRR = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data requester selection: data has priority, fetch is guaranteed a
// grant after MAX_DATA_RUN consecutive data grants made while it waited.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   f_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t owner
);

    localparam int unsigned RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);

    logic [RUN_W-1:0] run_cnt;
    logic             f_turn;

    always_comb begin
        f_turn = f_req && (run_cnt == RUN_W'(MAX_DATA_RUN));
        owner  = (d_req && !f_turn) ? OWN_D : OWN_F;
    end

    // Only D grants with F waiting extend the run; anything else restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (grant) begin
            if (owner == OWN_F || !f_req) begin
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 MAR/MDR access sequencer: grants one requester at a time, strobes MAR
// and MDR, runs the MEM_EN/MEM_R handshake with timeout and returns results.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned MAX_DATA_RUN   = DEF_MAX_DATA_RUN
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        F_REQ,
    input  logic [15:0] F_ADDR,
    output logic        F_DONE,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [15:0] D_ADDR,
    input  logic [15:0] D_WDATA,
    output logic        D_DONE,
    output logic [15:0] RDATA,
    output logic        ERR,
    output logic        LD_MAR,
    output logic [15:0] MAR_D,
    output logic        LD_MDR,
    output logic [15:0] MDR_D,
    output logic        MEM_EN,
    output logic        MEM_WE,
    input  logic        MEM_R,
    input  logic [15:0] MEM_RDATA
);

    state_t            state, state_nx;
    owner_t            owner_q, grant_owner;
    logic              we_q, err_q;
    logic [15:0]       addr_q, wdata_q, rdata_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              grant, wait_last;

    assign grant     = (state == ST_IDLE) && (F_REQ || D_REQ);
    assign wait_last = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    mem_arbiter #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_arbiter (
        .clk   (CLK),
        .reset (RESET),
        .f_req (F_REQ),
        .d_req (D_REQ),
        .grant (grant),
        .owner (grant_owner)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        F_DONE   = 1'b0;
        D_DONE   = 1'b0;
        RDATA    = '0;
        ERR      = 1'b0;
        LD_MAR   = 1'b0;
        MAR_D    = '0;
        LD_MDR   = 1'b0;
        MDR_D    = '0;
        MEM_EN   = 1'b0;
        MEM_WE   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (F_REQ || D_REQ) state_nx = ST_MAR;
            end
            ST_MAR: begin
                LD_MAR   = 1'b1;
                MAR_D    = addr_q;
                state_nx = we_q ? ST_MDRW : ST_ACC;
            end
            ST_MDRW: begin
                LD_MDR   = 1'b1;
                MDR_D    = wdata_q;
                state_nx = ST_ACC;
            end
            ST_ACC: begin
                MEM_EN = 1'b1;
                MEM_WE = we_q;
                // Ready in the last allowed cycle still completes normally.
                if (MEM_R) begin
                    state_nx = we_q ? ST_DONE : ST_MDRR;
                end else if (wait_last) begin
                    state_nx = ST_DONE;
                end
            end
            ST_MDRR: begin
                LD_MDR   = 1'b1;
                MDR_D    = rdata_q;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                F_DONE   = (owner_q == OWN_F);
                D_DONE   = (owner_q == OWN_D);
                RDATA    = (!we_q && !err_q) ? rdata_q : '0;
                ERR      = err_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_q  <= OWN_F;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q  <= grant_owner;
                        we_q     <= (grant_owner == OWN_D) && D_WE;
                        addr_q   <= (grant_owner == OWN_D) ? D_ADDR : F_ADDR;
                        wdata_q  <= (grant_owner == OWN_D) ? D_WDATA : '0;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        wait_cnt <= '0;
                    end
                end
                ST_ACC: begin
                    if (MEM_R) begin
                        if (!we_q) rdata_q <= MEM_RDATA;
                        wait_cnt <= '0;
                    end else if (wait_last) begin
                        err_q    <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer and arbiter for the LC-3 memory interface registers (MAR, MDR). Accepts memory requests from two requesters, instruction fetch (F) and execute-stage load/store (D), and grants one at a time. Drives the load strobes and data inputs of the 16-bit MAR and MDR register instances, runs the memory ready handshake with a timeout, and returns read data and completion to the owner.

## Interface
- TIMEOUT_CYCLES, 255: max MEM_EN cycles without MEM_R before abort (1..255).
- MAX_DATA_RUN, 4: consecutive D grants allowed while F is pending.

- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  synchronous, active-high
- F_REQ  in  1  fetch request, level
- F_ADDR  in  16  fetch address
- F_DONE  out  1  one-cycle completion pulse to F
- D_REQ  in  1  data request, level
- D_WE  in  1  1 = store, 0 = load
- D_ADDR  in  16  data address
- D_WDATA  in  16  store data
- D_DONE  out  1  one-cycle completion pulse to D
- RDATA  out  16  read result, valid with *_DONE
- ERR  out  1  timeout flag, valid with *_DONE
- LD_MAR  out  1  MAR load strobe
- MAR_D  out  16  MAR data input
- LD_MDR  out  1  MDR load strobe
- MDR_D  out  16  MDR data input
- MEM_EN  out  1  memory access enable
- MEM_WE  out  1  memory write enable
- MEM_R  in  1  memory ready
- MEM_RDATA  in  16  memory read data

## Operation
- States: IDLE, MAR, MDRW, ACC, MDRR, DONE. One-hot or binary; encoding fixed in package.
- IDLE: no strobes. If either REQ high: arbitrate, latch owner, WE (F is always read), address, write data; go to MAR.
- MAR: LD_MAR=1, MAR_D=latched address. Store -> MDRW, load -> ACC.
- MDRW: LD_MDR=1, MDR_D=latched write data. -> ACC.
- ACC: MEM_EN=1, MEM_WE=latched WE; wait counter increments per cycle. MEM_R=1: load captures MEM_RDATA -> MDRR; store -> DONE. Counter reaches TIMEOUT_CYCLES without MEM_R: set error -> DONE. MEM_R in the final timeout cycle wins (no error).
- MDRR: LD_MDR=1, MDR_D=captured read data. -> DONE.
- DONE: owner's DONE=1 for one cycle; RDATA=captured data (load, no error) else 16'h0000; ERR=error flag. -> IDLE. MDR not loaded on timeout.
- Arbitration: D has priority. Run counter counts D grants made while F_REQ high; when it equals MAX_DATA_RUN and both request, F is granted. Counter clears on any F grant or when D granted with F_REQ low.
- Requests are level: requester keeps REQ, address and data stable until its DONE, and clears REQ on the edge ending the DONE cycle. REQ high in the IDLE cycle after DONE is a new request.
- Requests arriving outside IDLE wait; no queueing beyond level REQ.

## Timing
- Reset (synchronous): state IDLE, all outputs 0, RDATA=16'h0000, wait and run counters 0, holding registers 0.
- RESET mid-operation: transaction abandoned, no DONE issued, MEM_EN low the cycle after the reset edge.
- Latency, MEM_R in first ACC cycle: request seen in IDLE cycle N -> DONE in cycle N+4 for both load and store. Each extra wait cycle adds 1.
- Timeout: DONE at cycle N+2+TIMEOUT_CYCLES (load) or N+3+TIMEOUT_CYCLES (store).
- Back-to-back: minimum 5 cycles per transaction (IDLE included).
- LD_MAR, LD_MDR, MEM_EN, *_DONE are registered-state decodes, glitch-free, exactly one cycle except MEM_EN.
- MAR_D/MDR_D are 0 when their strobe is low.

## Structure
- Shared package mem_ctrl_pkg: state encoding, owner encoding (OWN_F, OWN_D), default TIMEOUT_CYCLES/MAX_DATA_RUN, wait-counter width (8).
- Sub-module mem_arbiter: D-priority selection plus starvation run counter; outputs grant owner in IDLE. Remainder (FSM, holding registers, timeout counter, output decode) in mem_access_ctrl.

## Test plan
- F_REQ, F_ADDR=16'h3000, MEM_R returns 16'hABCD after 2 wait cycles -> LD_MAR with 16'h3000, LD_MDR with 16'hABCD, F_DONE at N+6, RDATA=16'hABCD, ERR=0.
- D store D_ADDR=16'h4000, D_WDATA=16'h1234, MEM_R immediate -> LD_MAR(16'h4000), LD_MDR(16'h1234), MEM_WE=1 one cycle, D_DONE at N+4.
- F_REQ and D_REQ held high continuously, MAX_DATA_RUN=4 -> grant order D,D,D,D,F,D,D,D,D,F.
- Load with MEM_R never asserted, TIMEOUT_CYCLES=8 -> MEM_EN high 8 cycles, D_DONE with ERR=1, RDATA=0, no LD_MDR.
- MEM_R asserted in eighth ACC cycle, TIMEOUT_CYCLES=8 -> normal completion, ERR=0.
- RESET pulsed during ACC -> next cycle IDLE, MEM_EN=0, no DONE; subsequent F request completes normally.
